// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS trace buffer: FSM encoding, entry layout and packed entry struct.
package mips_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

    localparam int PC_W      = 32;
    localparam int INSTR_W   = 32;
    localparam int ALU_W     = 32;
    localparam int PCSRC_W   = 2;

    localparam int PC_LSB    = 0;
    localparam int INSTR_LSB = PC_LSB + PC_W;
    localparam int ALU_LSB   = INSTR_LSB + INSTR_W;
    localparam int MEMW_LSB  = ALU_LSB + ALU_W;
    localparam int PCSRC_LSB = MEMW_LSB + 1;
    localparam int TRIG_LSB  = PCSRC_LSB + PCSRC_W;
    localparam int ENTRY_W   = TRIG_LSB + 1;

    // Field order matches the LSB offsets above (first member is the MSB).
    typedef struct packed {
        logic               is_trigger;
        logic [PCSRC_W-1:0] pc_source;
        logic               mem_write;
        logic [ALU_W-1:0]   alu_result;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: register array with synchronous write and asynchronous read, contents not reset.
module trace_ram
    import mips_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mips_trace_buffer.sv
// Post-mortem trace capture behind the single-cycle MIPS core: circular recording,
// PC-match/forced trigger with post-trigger window, oldest-first valid/ready drain.
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       instr_in,
    input  logic [31:0]       alu_result_in,
    input  logic              mem_write_in,
    input  logic [1:0]        pc_source_in,
    input  logic              arm,
    input  logic              clear,
    input  logic              trig_en,
    input  logic [31:0]       trigger_pc,
    input  logic              force_trig,
    input  logic [ADDR_W-1:0] post_count,
    output logic [1:0]        state_out,
    output logic              triggered,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [31:0]       rd_pc,
    output logic [31:0]       rd_instr,
    output logic [31:0]       rd_alu_result,
    output logic              rd_mem_write,
    output logic [1:0]        rd_pc_source,
    output logic              rd_is_trigger,
    output logic              rd_last
);

    localparam logic [ADDR_W:0]   FULL     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_P    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] POST_MAX = ADDR_W'(DEPTH - 1);

    function automatic logic [ADDR_W-1:0] clamp_post(input logic [ADDR_W-1:0] req);
        return (req > POST_MAX) ? POST_MAX : req;
    endfunction

    trace_state_e      state_q;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, remaining_q;
    logic [ADDR_W:0]   count_q, rd_left_q;
    logic              triggered_q, rd_valid_q;

    logic              recording, wr_en, trig_hit;
    logic [ADDR_W-1:0] wr_ptr_d, post_clamped;
    logic [ADDR_W:0]   count_d;
    logic [ENTRY_W-1:0] rd_raw;
    trace_entry_t      wr_entry, rd_entry;

    // arm and clear both suppress the cycle's write and trigger.
    assign recording    = (state_q == ARMED) || (state_q == POST);
    assign wr_en        = recording & capture_en & ~clear & ~arm;
    assign trig_hit     = (state_q == ARMED) & capture_en & ~clear & ~arm &
                          ((trig_en & (pc_in == trigger_pc)) | force_trig);
    assign wr_ptr_d     = wr_ptr_q + ONE_P;
    assign count_d      = (count_q == FULL) ? FULL : count_q + ONE_C;
    assign post_clamped = clamp_post(post_count);

    always_comb begin
        wr_entry            = '0;
        wr_entry.is_trigger = trig_hit;
        wr_entry.pc_source  = pc_source_in;
        wr_entry.mem_write  = mem_write_in;
        wr_entry.alu_result = alu_result_in;
        wr_entry.instr      = instr_in;
        wr_entry.pc         = pc_in;
    end

    trace_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_raw)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            rd_ptr_q    <= '0;
            rd_left_q   <= '0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            rd_ptr_q    <= '0;
            rd_left_q   <= '0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_q  <= ARMED;
                        wr_ptr_q <= '0;
                        count_q  <= '0;
                    end
                end
                ARMED, POST: begin
                    if (arm) begin
                        state_q     <= ARMED;
                        wr_ptr_q    <= '0;
                        count_q     <= '0;
                        remaining_q <= '0;
                        triggered_q <= 1'b0;
                    end else if (capture_en) begin
                        wr_ptr_q <= wr_ptr_d;
                        count_q  <= count_d;
                        if (trig_hit) begin
                            triggered_q <= 1'b1;
                            if (post_clamped == '0) begin
                                state_q    <= DONE;
                                rd_ptr_q   <= (count_d == FULL) ? wr_ptr_d : '0;
                                rd_left_q  <= count_d;
                                rd_valid_q <= 1'b1;
                            end else begin
                                state_q     <= POST;
                                remaining_q <= post_clamped;
                            end
                        end else if (state_q == POST) begin
                            remaining_q <= remaining_q - ONE_P;
                            // Window closes on the entry that takes remaining to zero.
                            if (remaining_q == ONE_P) begin
                                state_q    <= DONE;
                                rd_ptr_q   <= (count_d == FULL) ? wr_ptr_d : '0;
                                rd_left_q  <= count_d;
                                rd_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (rd_valid_q && rd_ready) begin
                        rd_ptr_q  <= rd_ptr_q + ONE_P;
                        rd_left_q <= rd_left_q - ONE_C;
                        if (rd_left_q == ONE_C) begin
                            state_q     <= IDLE;
                            rd_valid_q  <= 1'b0;
                            triggered_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_entry      = rd_raw;
    assign state_out     = state_q;
    assign triggered     = triggered_q;
    assign rd_valid      = rd_valid_q;
    assign rd_pc         = rd_valid_q ? rd_entry.pc         : '0;
    assign rd_instr      = rd_valid_q ? rd_entry.instr      : '0;
    assign rd_alu_result = rd_valid_q ? rd_entry.alu_result : '0;
    assign rd_mem_write  = rd_valid_q & rd_entry.mem_write;
    assign rd_pc_source  = rd_valid_q ? rd_entry.pc_source  : '0;
    assign rd_is_trigger = rd_valid_q & rd_entry.is_trigger;
    assign rd_last       = rd_valid_q & (rd_left_q == ONE_C);

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer: capture windows, wrap, backpressure, control edges.
module tb_mips_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              reset;
    logic              capture_en;
    logic [31:0]       pc_in;
    logic [31:0]       instr_in;
    logic [31:0]       alu_result_in;
    logic              mem_write_in;
    logic [1:0]        pc_source_in;
    logic              arm;
    logic              clear;
    logic              trig_en;
    logic [31:0]       trigger_pc;
    logic              force_trig;
    logic [ADDR_W-1:0] post_count;
    logic [1:0]        state_out;
    logic              triggered;
    logic              rd_valid;
    logic              rd_ready;
    logic [31:0]       rd_pc;
    logic [31:0]       rd_instr;
    logic [31:0]       rd_alu_result;
    logic              rd_mem_write;
    logic [1:0]        rd_pc_source;
    logic              rd_is_trigger;
    logic              rd_last;

    mips_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .capture_en    (capture_en),
        .pc_in         (pc_in),
        .instr_in      (instr_in),
        .alu_result_in (alu_result_in),
        .mem_write_in  (mem_write_in),
        .pc_source_in  (pc_source_in),
        .arm           (arm),
        .clear         (clear),
        .trig_en       (trig_en),
        .trigger_pc    (trigger_pc),
        .force_trig    (force_trig),
        .post_count    (post_count),
        .state_out     (state_out),
        .triggered     (triggered),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_pc         (rd_pc),
        .rd_instr      (rd_instr),
        .rd_alu_result (rd_alu_result),
        .rd_mem_write  (rd_mem_write),
        .rd_pc_source  (rd_pc_source),
        .rd_is_trigger (rd_is_trigger),
        .rd_last       (rd_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] expq [$];

    typedef struct {
        logic        cen;
        logic [31:0] pc;
        logic        ft;
        logic [1:0]  exp_state;
        logic        exp_trig;
    } step_t;
    step_t gap_tbl [8];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] alu_of(input logic [31:0] pc);
        return pc + 32'h0000_1000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic feed(input logic [31:0] pc, input logic cen, input logic ft);
        logic [31:0] p;
        p             = pc;
        capture_en    = cen;
        pc_in         = p;
        instr_in      = instr_of(p);
        alu_result_in = alu_of(p);
        mem_write_in  = p[2];
        pc_source_in  = p[3:2];
        force_trig    = ft;
        @(negedge clk);
        capture_en    = 1'b0;
        force_trig    = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic drain(input int trig_idx, input bit bp);
        int k;
        int cyc;
        int n;
        bit r;
        bit pat [6];
        logic [31:0] e;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        k   = 0;
        cyc = 0;
        n   = expq.size();
        while (k < n && cyc < 400) begin
            e = expq[k];
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_pc", rd_pc, e);
            chk("rd_instr", rd_instr, instr_of(e));
            chk("rd_alu_result", rd_alu_result, alu_of(e));
            chk("rd_mem_write", 32'(rd_mem_write), 32'(e[2]));
            chk("rd_pc_source", 32'(rd_pc_source), 32'(e[3:2]));
            chk("rd_is_trigger", 32'(rd_is_trigger), 32'(k == trig_idx));
            chk("rd_last", 32'(rd_last), 32'(k == n - 1));
            r = bp ? pat[cyc % 6] : 1'b1;
            rd_ready = r;
            @(negedge clk);
            cyc++;
            if (r) k++;
        end
        rd_ready = 1'b0;
        chk("drain_len", 32'(k), 32'(n));
        chk("drain_state", 32'(state_out), 32'd0);
        chk("drain_valid", 32'(rd_valid), 32'd0);
        chk("drain_triggered", 32'(triggered), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        gap_tbl[0] = '{1'b1, 32'h00, 1'b0, 2'd1, 1'b0};
        gap_tbl[1] = '{1'b0, 32'h08, 1'b0, 2'd1, 1'b0};
        gap_tbl[2] = '{1'b1, 32'h04, 1'b0, 2'd1, 1'b0};
        gap_tbl[3] = '{1'b1, 32'h08, 1'b0, 2'd2, 1'b1};
        gap_tbl[4] = '{1'b0, 32'h0C, 1'b0, 2'd2, 1'b1};
        gap_tbl[5] = '{1'b1, 32'h0C, 1'b0, 2'd2, 1'b1};
        gap_tbl[6] = '{1'b0, 32'h10, 1'b0, 2'd2, 1'b1};
        gap_tbl[7] = '{1'b1, 32'h10, 1'b0, 2'd3, 1'b1};

        reset = 1'b0; capture_en = 1'b0; pc_in = '0; instr_in = '0; alu_result_in = '0;
        mem_write_in = 1'b0; pc_source_in = '0; arm = 1'b0; clear = 1'b0; trig_en = 1'b0;
        trigger_pc = '0; force_trig = 1'b0; post_count = '0; rd_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_triggered", 32'(triggered), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_pc", rd_pc, 32'd0);
        chk("reset_rd_last", 32'(rd_last), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_state", 32'(state_out), 32'd0);

        // Wrap-around window: trigger at 0x40, three post entries.
        trig_en = 1'b1; trigger_pc = 32'h40; post_count = 4'd3;
        pulse_arm();
        chk("wrap_armed", 32'(state_out), 32'd1);
        for (int i = 0; i < 20; i++) begin
            feed(32'(i * 4), 1'b1, 1'b0);
            if (i == 15) chk("wrap_pre_trig", 32'(triggered), 32'd0);
            if (i == 16) begin
                chk("wrap_post_state", 32'(state_out), 32'd2);
                chk("wrap_triggered", 32'(triggered), 32'd1);
            end
            if (i == 18) chk("wrap_still_post", 32'(state_out), 32'd2);
        end
        chk("wrap_done", 32'(state_out), 32'd3);
        expq.delete();
        for (int i = 4; i < 20; i++) expq.push_back(32'(i * 4));
        drain(12, 1'b0);

        // No wrap, drained under backpressure.
        trigger_pc = 32'h08; post_count = 4'd2;
        pulse_arm();
        for (int i = 0; i < 5; i++) feed(32'(i * 4), 1'b1, 1'b0);
        chk("nowrap_done", 32'(state_out), 32'd3);
        expq.delete();
        for (int i = 0; i < 5; i++) expq.push_back(32'(i * 4));
        drain(2, 1'b1);

        // Forced trigger with post_count=0: trigger entry is the last one read.
        trig_en = 1'b0; post_count = 4'd0;
        pulse_arm();
        for (int i = 0; i < 9; i++) feed(32'(i * 4), 1'b1, 1'b0);
        chk("force_armed", 32'(state_out), 32'd1);
        feed(32'h24, 1'b1, 1'b1);
        chk("force_done", 32'(state_out), 32'd3);
        expq.delete();
        for (int i = 0; i < 10; i++) expq.push_back(32'(i * 4));
        drain(9, 1'b0);

        // post_count=15 fills the whole buffer after the trigger; the trigger entry is the oldest kept.
        trig_en = 1'b1; trigger_pc = 32'h04; post_count = 4'd15;
        pulse_arm();
        for (int i = 0; i < 17; i++) begin
            feed(32'(i * 4), 1'b1, 1'b0);
            if (i == 15) chk("pc15_post", 32'(state_out), 32'd2);
        end
        chk("pc15_done", 32'(state_out), 32'd3);
        expq.delete();
        for (int i = 1; i < 17; i++) expq.push_back(32'(i * 4));
        drain(0, 1'b0);

        // capture_en gaps: disabled matches don't trigger, remaining only counts enabled cycles.
        trigger_pc = 32'h08; post_count = 4'd2;
        pulse_arm();
        for (int s = 0; s < 8; s++) begin
            feed(gap_tbl[s].pc, gap_tbl[s].cen, gap_tbl[s].ft);
            chk($sformatf("gap_state_%0d", s), 32'(state_out), 32'(gap_tbl[s].exp_state));
            chk($sformatf("gap_trig_%0d", s), 32'(triggered), 32'(gap_tbl[s].exp_trig));
        end
        expq.delete();
        for (int i = 0; i < 5; i++) expq.push_back(32'(i * 4));
        drain(2, 1'b0);

        // arm during POST restarts with an empty buffer.
        trigger_pc = 32'h04; post_count = 4'd5;
        pulse_arm();
        feed(32'h00, 1'b1, 1'b0);
        feed(32'h04, 1'b1, 1'b0);
        feed(32'h08, 1'b1, 1'b0);
        chk("rearm_in_post", 32'(state_out), 32'd2);
        capture_en = 1'b1; pc_in = 32'h0C;
        pulse_arm();
        capture_en = 1'b0;
        chk("rearm_state", 32'(state_out), 32'd1);
        chk("rearm_triggered", 32'(triggered), 32'd0);
        trigger_pc = 32'h24; post_count = 4'd0;
        feed(32'h20, 1'b1, 1'b0);
        feed(32'h24, 1'b1, 1'b0);
        chk("rearm_done", 32'(state_out), 32'd3);
        expq.delete();
        expq.push_back(32'h20);
        expq.push_back(32'h24);
        drain(1, 1'b0);

        // arm ignored in DONE; clear aborts the drain.
        trig_en = 1'b0; post_count = 4'd0;
        pulse_arm();
        feed(32'h100, 1'b1, 1'b0);
        feed(32'h104, 1'b1, 1'b1);
        chk("clr_done", 32'(state_out), 32'd3);
        pulse_arm();
        chk("arm_in_done", 32'(state_out), 32'd3);
        chk("arm_in_done_pc", rd_pc, 32'h100);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("clr_second_pc", rd_pc, 32'h104);
        chk("clr_second_last", 32'(rd_last), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_state", 32'(state_out), 32'd0);
        chk("clr_valid", 32'(rd_valid), 32'd0);
        chk("clr_rd_pc", rd_pc, 32'd0);
        chk("clr_triggered", 32'(triggered), 32'd0);

        // Asynchronous reset in the middle of POST.
        trig_en = 1'b1; trigger_pc = 32'h00; post_count = 4'd5;
        pulse_arm();
        feed(32'h00, 1'b1, 1'b0);
        feed(32'h04, 1'b1, 1'b0);
        chk("rst_in_post", 32'(state_out), 32'd2);
        chk("rst_trig_before", 32'(triggered), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_state", 32'(state_out), 32'd0);
        chk("rst_async_trig", 32'(triggered), 32'd0);
        chk("rst_async_valid", 32'(rd_valid), 32'd0);
        chk("rst_async_pc", rd_pc, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_after_state", 32'(state_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
